// File: rtl/atsc_segment_packer.sv
// ATSC segment packer. Regroups the Viterbi byte stream (4 bytes per word) into
// RS segments of SEG_BYTES bytes. Each segment is one output packet, with
// o_tlast on its last word. Unused lanes of that word are filled with PAD_BYTE.
// An input word with i_tlast marks the end of a field. A partial segment still
// open at that point is flushed early and counted as an error.
//
// Ports:
//   ce_clk, ce_rst     clock, synchronous active-high reset
//   i_tdata/i_tvalid/i_tlast/i_tready   input byte stream, byte 0 in [31:24]
//   o_tdata/o_tvalid/o_tlast/o_tready   output segment stream, registered
//   seg_count          segments emitted (wraps)
//   err_count          short segments flushed by i_tlast (saturates)
module atsc_segment_packer #(
  parameter int unsigned SEG_BYTES = 207,
  parameter logic [7:0]  PAD_BYTE  = 8'h00,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic [31:0]      i_tdata,
  input  logic             i_tvalid,
  input  logic             i_tlast,
  output logic             i_tready,
  output logic [31:0]      o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  input  logic             o_tready,
  output logic [CNT_W-1:0] seg_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PosW = $clog2(SEG_BYTES + 1);

  // 8-byte FIFO. Index 0 is the oldest byte.
  logic [7:0]       buf_q [8];
  logic [7:0]       buf_d [8];
  logic [3:0]       level_q, level_d;
  // fe0/fe1 give the byte count from the head up to and including a pending
  // field end. A value of 0 means none is pending. The FIFO holds at most two
  // field ends at once.
  logic [3:0]       fe0_q, fe0_d, fe1_q, fe1_d;
  logic [PosW-1:0]  seg_pos_q, seg_pos_d;
  logic [31:0]      o_tdata_q, o_tdata_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic             o_tlast_q, o_tlast_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [PosW-1:0]  rem;
  logic [3:0]       rem4;
  logic             rem_big;
  logic             load_ok, do_load, seg_end, err_inc, accept;
  logic [3:0]       pop, lvl_rem, fe0_n, fe1_n;

  // seg_pos only ever advances by 4, and SEG_BYTES is not a multiple of 4.
  // So rem is either above 4 or in the range 1..3.
  assign rem     = PosW'(SEG_BYTES) - seg_pos_q;
  assign rem_big = rem > PosW'(4);
  assign rem4    = {1'b0, rem[2:0]};
  assign load_ok = !o_tvalid_q || o_tready;

  always_comb begin
    pop     = 4'd0;
    do_load = 1'b0;
    seg_end = 1'b0;
    err_inc = 1'b0;
    if (load_ok) begin
      if (rem_big) begin
        if (fe0_q != 4'd0 && fe0_q <= 4'd4) begin
          pop = fe0_q; do_load = 1'b1; seg_end = 1'b1; err_inc = 1'b1;
        end else if (level_q >= 4'd4) begin
          pop = 4'd4; do_load = 1'b1;
        end
      end else begin
        if (fe0_q != 4'd0 && fe0_q < rem4) begin
          pop = fe0_q; do_load = 1'b1; seg_end = 1'b1; err_inc = 1'b1;
        end else if (level_q >= rem4) begin
          // Covers a field end that falls exactly on the segment end.
          pop = rem4; do_load = 1'b1; seg_end = 1'b1;
        end
      end
    end
  end

  assign lvl_rem  = level_q - pop;
  assign i_tready = lvl_rem <= 4'd4;
  assign accept   = i_tvalid && i_tready;

  always_comb begin
    // Pop from the head, then append the accepted word right after the survivors.
    for (int i = 0; i < 8; i++) begin
      buf_d[i] = 8'h00;
      if (4'(i) + pop < 4'd8) buf_d[i] = buf_q[3'(4'(i) + pop)];
    end
    if (accept) begin
      for (int j = 0; j < 4; j++) buf_d[lvl_rem[2:0] + 3'(j)] = i_tdata[31-8*j -: 8];
    end
    level_d = accept ? lvl_rem + 4'd4 : lvl_rem;

    fe0_n = (fe0_q != 4'd0) ? fe0_q - pop : 4'd0;
    fe1_n = (fe1_q != 4'd0) ? fe1_q - pop : 4'd0;
    if (fe0_q != 4'd0 && fe0_n == 4'd0) begin
      fe0_d = fe1_n;
      fe1_d = 4'd0;
    end else begin
      fe0_d = fe0_n;
      fe1_d = fe1_n;
    end
    if (accept && i_tlast) begin
      if (fe0_d == 4'd0) fe0_d = level_d;
      else               fe1_d = level_d;
    end

    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q && !o_tready;
    seg_pos_d  = seg_pos_q;
    seg_cnt_d  = seg_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (do_load) begin
      for (int j = 0; j < 4; j++) begin
        o_tdata_d[31-8*j -: 8] = (4'(j) < pop) ? buf_q[j] : PAD_BYTE;
      end
      o_tlast_d  = seg_end;
      o_tvalid_d = 1'b1;
      seg_pos_d  = seg_end ? '0 : seg_pos_q + PosW'(4);
      if (seg_end) seg_cnt_d = seg_cnt_q + CNT_W'(1);
      if (err_inc && err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'h00;
      level_q    <= 4'd0;
      fe0_q      <= 4'd0;
      fe1_q      <= 4'd0;
      seg_pos_q  <= '0;
      o_tdata_q  <= 32'h0;
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      seg_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) buf_q[i] <= buf_d[i];
      level_q    <= level_d;
      fe0_q      <= fe0_d;
      fe1_q      <= fe1_d;
      seg_pos_q  <= seg_pos_d;
      o_tdata_q  <= o_tdata_d;
      o_tvalid_q <= o_tvalid_d;
      o_tlast_q  <= o_tlast_d;
      seg_cnt_q  <= seg_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_tdata   = o_tdata_q;
  assign o_tvalid  = o_tvalid_q;
  assign o_tlast   = o_tlast_q;
  assign seg_count = seg_cnt_q;
  assign err_count = err_cnt_q;

endmodule
